mdu_ctrl: RTL and testbench

Multiply/divide unit controller for the P6 pipeline. Owns the HI/LO registers, sequences multi-cycle mult/multu/div/divu started from the E stage, and services mthi/mtlo/mfhi/mflo. Generates the D-stage stall for any md/mt/mf instruction while the unit is occupied. Sits beside the ALU in E; its read port feeds the `RFWD_HILOout` source of the writeback mux.

---
 rtl/mdu_ctrl_pkg.sv | 14 +
 rtl/mdu_calc.sv | 29 ++
 rtl/mdu_ctrl.sv | 85 ++++++++
 tb/tb_mdu_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: HI/LO operation codes and default multiply/divide latencies
package mdu_ctrl_pkg;
  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;
  localparam logic [3:0] HILO_none  = 4'd0;
  localparam logic [3:0] HILO_mult  = 4'd1;
  localparam logic [3:0] HILO_multu = 4'd2;
  localparam logic [3:0] HILO_div   = 4'd3;
  localparam logic [3:0] HILO_divu  = 4'd4;
  localparam logic [3:0] HILO_mthi  = 4'd5;
  localparam logic [3:0] HILO_mtlo  = 4'd6;
  localparam logic [3:0] HILO_mfhi  = 4'd7;
  localparam logic [3:0] HILO_mflo  = 4'd8;
endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational mult/multu/div/divu result for the latched operation
module mdu_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o,
  output logic        div_zero_o
);
  logic        is_div, sgn_mul, a_neg, b_neg;
  logic [31:0] ua, ub, ub_safe, uq, ur;
  logic [63:0] prod;
  // Signed divide runs on magnitudes and fixes signs afterwards, which also yields 0x80000000/-1 = 0x80000000, rem 0
  always_comb begin
    is_div     = (op_i == HILO_div) || (op_i == HILO_divu);
    sgn_mul    = op_i == HILO_mult;
    a_neg      = (op_i == HILO_div) & a_i[31];
    b_neg      = (op_i == HILO_div) & b_i[31];
    ua         = a_neg ? -a_i : a_i;
    ub         = b_neg ? -b_i : b_i;
    ub_safe    = (ub == '0) ? 32'd1 : ub;
    uq         = ua / ub_safe;
    ur         = ua % ub_safe;
    prod       = {{32{sgn_mul & a_i[31]}}, a_i} * {{32{sgn_mul & b_i[31]}}, b_i};
    div_zero_o = is_div & (b_i == '0);
    res_o      = is_div ? {a_neg ? -ur : ur, (a_neg ^ b_neg) ? -uq : uq} : prod;
  end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO owner that sequences multi-cycle mult/div and services mt/mf with D-stage stall
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  hilo_type,
  input  logic        valid_e,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_d,
  input  logic        mt_d,
  input  logic        mf_d,
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hilo_rd
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0]   res;
  logic          div_zero, is_md, is_mul, is_mt;
  mdu_calc u_calc (
    .op_i       (op_q),
    .a_i        (a_q),
    .b_i        (b_q),
    .res_o      (res),
    .div_zero_o (div_zero)
  );
  // Accept md ops when idle, count down while busy, commit on the last busy cycle, mt writes when idle
  always_comb begin
    is_mul  = (hilo_type == HILO_mult) || (hilo_type == HILO_multu);
    is_md   = is_mul || (hilo_type == HILO_div) || (hilo_type == HILO_divu);
    is_mt   = (hilo_type == HILO_mthi) || (hilo_type == HILO_mtlo);
    busy    = cnt_q != '0;
    start   = valid_e & ~busy & is_md;
    stall   = (md_d | mt_d | mf_d) & (busy | start);
    hilo_rd = (hilo_type == HILO_mfhi) ? hi_q : (hilo_type == HILO_mflo) ? lo_q : '0;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (start) begin
      op_d  = hilo_type;
      a_d   = rs_val;
      b_d   = rt_val;
      cnt_d = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end else if (busy) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1) && !div_zero) {hi_d, lo_d} = res;
    end else if (valid_e && hilo_type == HILO_mthi) begin
      hi_d = rs_val;
    end else if (valid_e && hilo_type == HILO_mtlo) begin
      lo_d = rs_val;
    end
  end
  // State register; reset clears everything and wins over a same-edge start
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      op_q  <= HILO_none;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end
  a_no_md_mt_while_busy: assert property (@(posedge clk) disable iff (!reset)
    !(busy && valid_e && (is_md || is_mt)));
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard-driven scenarios for the multiply/divide controller
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;
  localparam int MC = 5;
  localparam int DC = 10;
  logic        clk = 0, reset = 0, valid_e = 0, md_d = 0, mt_d = 0, mf_d = 0;
  logic [3:0]  hilo_type = HILO_none;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        start, busy, stall;
  logic [31:0] hilo_rd;
  int          checks = 0, errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] hi_m = '0, lo_m = '0;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .hilo_type (hilo_type),
    .valid_e   (valid_e),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .md_d      (md_d),
    .mt_d      (mt_d),
    .mf_d      (mf_d),
    .start     (start),
    .busy      (busy),
    .stall     (stall),
    .hilo_rd   (hilo_rd)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (op == HILO_mult) return sa * sb;
    if (op == HILO_multu) return ua * ub;
    if (b == '0) return {hi_m, lo_m};
    if (op == HILO_div) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    q = longint'(ua / ub);
    r = longint'(ua % ub);
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one md op with an mf waiting in D, verify busy window, stall, no early commit, then read back
  task automatic do_md(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int n);
    logic [63:0] e, old;
    old = {hi_m, lo_m};
    hilo_type = op; valid_e = 1; rs_val = a; rt_val = b; mf_d = 1;
    #1;
    checks++;
    if (start !== 1'b1 || stall !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s_start: start=%b stall=%b busy=%b expected 1 1 0", tag, start, stall, busy);
    if (start !== 1'b1 || stall !== 1'b1 || busy !== 1'b0) errors++;
    e = model(op, a, b);
    sb_q.push_back(e);
    {hi_m, lo_m} = e;
    tick;
    valid_e = 0; hilo_type = HILO_mflo;
    for (int i = 1; i <= n; i++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || stall !== 1'b1 || hilo_rd !== old[31:0]) begin
        errors++;
        $display("FAIL %s_busy%0d: busy=%b stall=%b lo=%h expected 1 1 %h", tag, i, busy, stall, hilo_rd, old[31:0]);
      end
      tick;
    end
    valid_e = 1;
    #1;
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: busy=%b stall=%b expected 0 0", tag, busy, stall);
    end
    e = sb_q.pop_front();
    checks++;
    if (hilo_rd !== e[31:0]) begin
      errors++;
      $display("FAIL %s_lo: got %h expected %h", tag, hilo_rd, e[31:0]);
    end
    hilo_type = HILO_mfhi;
    #1;
    checks++;
    if (hilo_rd !== e[63:32]) begin
      errors++;
      $display("FAIL %s_hi: got %h expected %h", tag, hilo_rd, e[63:32]);
    end
    tick;
    valid_e = 0; hilo_type = HILO_none; mf_d = 0;
  endtask

  task automatic test_reset;
    reset = 0; md_d = 1;
    tick; tick;
    hilo_type = HILO_mult;
    #1;
    checks++;
    if (busy !== 1'b0 || start !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: busy=%b start=%b stall=%b expected 0 0 0", busy, start, stall);
    end
    hilo_type = HILO_mfhi;
    #1;
    checks++;
    if (hilo_rd !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hilo_rd); end
    hilo_type = HILO_mflo;
    #1;
    checks++;
    if (hilo_rd !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", hilo_rd); end
    md_d = 0; hilo_type = HILO_none; reset = 1;
    tick;
  endtask

  task automatic test_mult;
    do_md("mult", HILO_mult, 32'hFFFFFFFE, 32'd3, MC);
    hilo_type = HILO_mfhi;
    #1;
    checks++;
    if (hilo_rd !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi_const: got %h expected ffffffff", hilo_rd); end
    do_md("multu", HILO_multu, 32'hFFFFFFFE, 32'd3, MC);
    hilo_type = HILO_mfhi;
    #1;
    checks++;
    if (hilo_rd !== 32'h2) begin errors++; $display("FAIL multu_hi_const: got %h expected 2", hilo_rd); end
    hilo_type = HILO_mflo;
    #1;
    checks++;
    if (hilo_rd !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu_lo_const: got %h expected fffffffa", hilo_rd); end
    do_md("mult_big", HILO_mult, 32'h80000000, 32'h80000000, MC);
    hilo_type = HILO_none;
  endtask

  task automatic test_div;
    do_md("div", HILO_div, 32'hFFFFFFF9, 32'd2, DC);
    hilo_type = HILO_mflo;
    #1;
    checks++;
    if (hilo_rd !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo_const: got %h expected fffffffd", hilo_rd); end
    do_md("div_ovf", HILO_div, 32'h80000000, 32'hFFFFFFFF, DC);
    hilo_type = HILO_mfhi;
    #1;
    checks++;
    if (hilo_rd !== 32'h0) begin errors++; $display("FAIL div_ovf_hi_const: got %h expected 0", hilo_rd); end
    do_md("div_neg", HILO_div, 32'd100, 32'hFFFFFFF9, DC);
    do_md("divu", HILO_divu, 32'hFFFFFFF9, 32'd10, DC);
    do_md("divu_zero", HILO_divu, 32'd7, 32'd0, DC);
    do_md("div_zero", HILO_div, 32'hFFFFFFF9, 32'd0, DC);
    hilo_type = HILO_none;
  endtask

  task automatic test_mt;
    valid_e = 1; hilo_type = HILO_mthi; rs_val = 32'h12345678;
    #1;
    checks++;
    if (start !== 1'b0) begin errors++; $display("FAIL mthi_start: got %b expected 0", start); end
    tick;
    hilo_type = HILO_mfhi;
    #1;
    checks++;
    if (hilo_rd !== 32'h12345678) begin errors++; $display("FAIL mthi_rd: got %h expected 12345678", hilo_rd); end
    tick;
    valid_e = 0; hilo_type = HILO_mthi; rs_val = 32'hDEADBEEF;
    tick;
    hilo_type = HILO_mfhi;
    #1;
    checks++;
    if (hilo_rd !== 32'h12345678) begin errors++; $display("FAIL mthi_bubble: got %h expected 12345678", hilo_rd); end
    valid_e = 1; hilo_type = HILO_mtlo; rs_val = 32'hCAFE0001;
    tick;
    hilo_type = HILO_mflo;
    #1;
    checks++;
    if (hilo_rd !== 32'hCAFE0001) begin errors++; $display("FAIL mtlo_rd: got %h expected cafe0001", hilo_rd); end
    hi_m = 32'h12345678; lo_m = 32'hCAFE0001;
    tick;
    valid_e = 0; hilo_type = HILO_none;
  endtask

  task automatic test_back_to_back;
    logic [63:0] e;
    hilo_type = HILO_mult; valid_e = 1; rs_val = 32'd1000; rt_val = 32'hFFFFFF00; md_d = 1;
    #1;
    checks++;
    if (start !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL b2b_start1: start=%b stall=%b expected 1 1", start, stall); end
    e = model(HILO_mult, rs_val, rt_val);
    sb_q.push_back(e);
    {hi_m, lo_m} = e;
    tick;
    valid_e = 0; hilo_type = HILO_none;
    for (int i = 1; i <= MC; i++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL b2b_hold%0d: busy=%b stall=%b expected 1 1", i, busy, stall); end
      tick;
    end
    md_d = 0; mt_d = 1; valid_e = 1; hilo_type = HILO_divu; rs_val = 32'd55; rt_val = 32'd0;
    #1;
    checks++;
    if (start !== 1'b1 || busy !== 1'b0 || stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start2: start=%b busy=%b stall=%b expected 1 0 1", start, busy, stall);
    end
    sb_q.push_back(model(HILO_divu, rs_val, rt_val));
    tick;
    valid_e = 0; hilo_type = HILO_none;
    for (int i = 1; i <= DC; i++) tick;
    mt_d = 0;
    for (int k = 0; k < 2; k++) begin
      e = sb_q.pop_front();
      hilo_type = HILO_mflo;
      #1;
      checks++;
      if (hilo_rd !== e[31:0]) begin errors++; $display("FAIL b2b_lo%0d: got %h expected %h", k, hilo_rd, e[31:0]); end
      hilo_type = HILO_mfhi;
      #1;
      checks++;
      if (hilo_rd !== e[63:32]) begin errors++; $display("FAIL b2b_hi%0d: got %h expected %h", k, hilo_rd, e[63:32]); end
    end
    hilo_type = HILO_none;
    tick;
  endtask

  task automatic test_reset_mid;
    valid_e = 1; hilo_type = HILO_div; rs_val = 32'hFFFFFFF9; rt_val = 32'd2;
    tick;
    valid_e = 0; hilo_type = HILO_none;
    tick; tick;
    reset = 0;
    tick;
    reset = 1; hilo_type = HILO_mflo;
    for (int i = 0; i < DC + 2; i++) begin
      #1;
      checks++;
      if (busy !== 1'b0 || hilo_rd !== 32'h0) begin
        errors++;
        $display("FAIL rstmid_%0d: busy=%b lo=%h expected 0 0", i, busy, hilo_rd);
      end
      tick;
    end
    hilo_type = HILO_mfhi;
    #1;
    checks++;
    if (hilo_rd !== 32'h0) begin errors++; $display("FAIL rstmid_hi: got %h expected 0", hilo_rd); end
    hi_m = '0; lo_m = '0;
    hilo_type = HILO_none;
  endtask

  task automatic test_reset_start;
    valid_e = 1; hilo_type = HILO_mtlo; rs_val = 32'h0000A5A5;
    tick;
    reset = 0; hilo_type = HILO_mult; rs_val = 32'd7; rt_val = 32'd9;
    tick;
    reset = 1; valid_e = 0; hilo_type = HILO_mflo;
    for (int i = 0; i < MC + 2; i++) begin
      #1;
      checks++;
      if (busy !== 1'b0 || hilo_rd !== 32'h0) begin
        errors++;
        $display("FAIL rststart_%0d: busy=%b lo=%h expected 0 0", i, busy, hilo_rd);
      end
      tick;
    end
    hilo_type = HILO_none;
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_mt;
    test_back_to_back;
    test_reset_mid;
    test_reset_start;
    do_md("mult_after_rst", HILO_mult, 32'd6, 32'hFFFFFFF9, MC);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
